// File: rtl/vector_reverse_arbiter_if.sv
// rtl/vector_reverse_arbiter_if.sv - requester, result and counter signals of the reversing arbiter
interface vector_reverse_arbiter_if #(
    parameter int WIDTH = 100
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic [15:0]      grant_cnt0;
    logic [15:0]      grant_cnt1;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src,
        output grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/vector_reverse_arbiter.sv
// rtl/vector_reverse_arbiter.sv - two-requester round-robin arbiter feeding one bit-reversal output register
module vector_reverse_arbiter #(
    parameter int WIDTH = 100
) (
    input  logic                    clk,
    input  logic                    resetn,
    vector_reverse_arbiter_if.slave bus
);
    logic             load_en;
    logic             grant0;
    logic             grant1;
    logic             ptr;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] rev_data;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;
    logic [15:0]      cnt0_q;
    logic [15:0]      cnt1_q;

    // resetn gates load_en so both readys stay low for the whole reset pulse
    always_comb begin
        load_en = resetn && (!out_valid_q || bus.out_ready);
        grant0  = load_en && bus.req0_valid && (!bus.req1_valid || !ptr);
        grant1  = load_en && bus.req1_valid && (!bus.req0_valid || ptr);
    end

    always_comb begin
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
        rev_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_data[WIDTH-1-i] = sel_data[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            ptr         <= 1'b0;
            cnt0_q      <= 16'h0000;
            cnt1_q      <= 16'h0000;
        end else if (grant0 || grant1) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rev_data;
            out_src_q   <= grant1;
            ptr         <= grant0;
            if (grant0) begin
                cnt0_q <= cnt0_q + 16'h0001;
            end else begin
                cnt1_q <= cnt1_q + 16'h0001;
            end
        end else if (load_en) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
endmodule
